// File: rtl/cache_dma_responder.sv
// rtl/cache_dma_responder.sv - cache line fill / dirty writeback engine
// Serialises one line at a time over a single-word memory port, evictions first.
module cache_dma_responder #(
   parameter int BLOCK_BITS = 512,
   parameter int WORD_BITS  = 32,
   parameter int ADDR_BITS  = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_i,
   input  logic [ADDR_BITS-1:0]  req_addr_i,
   output logic [BLOCK_BITS-1:0] fill_data_o,
   output logic [ADDR_BITS-1:0]  fill_addr_o,
   output logic                  fill_valid_o,
   input  logic                  evict_i,
   input  logic [ADDR_BITS-1:0]  evict_addr_i,
   input  logic [BLOCK_BITS-1:0] evict_data_i,
   output logic                  evict_ack_o,
   output logic [ADDR_BITS-1:0]  mem_addr_o,
   output logic                  mem_rd_o,
   output logic                  mem_wr_o,
   output logic [WORD_BITS-1:0]  mem_wdata_o,
   input  logic [WORD_BITS-1:0]  mem_rdata_i,
   output logic                  busy_o
);

   localparam int WORDS     = BLOCK_BITS / WORD_BITS;
   localparam int CNT_BITS  = $clog2(WORDS);
   localparam int BYTE_BITS = $clog2(WORD_BITS / 8);
   localparam int OFFS      = CNT_BITS + BYTE_BITS;
   localparam int LINE_BITS = ADDR_BITS - OFFS;
   localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(WORDS - 1);

   typedef enum logic [2:0] {IDLE, WB, WB_ACK, RD, RD_DRAIN, FILL_RSP} state_t;

   state_t               state, state_next;
   logic [CNT_BITS-1:0]  cnt, cnt_next, prev_cnt;
   logic [LINE_BITS-1:0] line_addr;
   logic [WORD_BITS-1:0] words [WORDS];
   logic                 accept_evict, accept_req;
   logic                 unused_offset_bits;

   assign unused_offset_bits = ^{req_addr_i[OFFS-1:0], evict_addr_i[OFFS-1:0]};
   assign prev_cnt = cnt - 1'b1;

   always_comb begin
      state_next   = state;
      cnt_next     = '0;
      accept_evict = 1'b0;
      accept_req   = 1'b0;
      mem_rd_o     = 1'b0;
      mem_wr_o     = 1'b0;
      mem_addr_o   = '0;
      mem_wdata_o  = '0;
      fill_valid_o = 1'b0;
      evict_ack_o  = 1'b0;
      busy_o       = (state != IDLE);
      case (state)
         IDLE: begin
            if (evict_i) begin
               accept_evict = 1'b1;
               state_next   = WB;
            end else if (req_i) begin
               accept_req = 1'b1;
               state_next = RD;
            end
         end
         WB: begin
            mem_wr_o    = 1'b1;
            mem_addr_o  = {line_addr, cnt, {BYTE_BITS{1'b0}}};
            mem_wdata_o = words[cnt];
            if (cnt == LAST) state_next = WB_ACK;
            else             cnt_next   = cnt + 1'b1;
         end
         WB_ACK: begin
            evict_ack_o = 1'b1;
            state_next  = IDLE;
         end
         RD: begin
            mem_rd_o   = 1'b1;
            mem_addr_o = {line_addr, cnt, {BYTE_BITS{1'b0}}};
            if (cnt == LAST) state_next = RD_DRAIN;
            else             cnt_next   = cnt + 1'b1;
         end
         RD_DRAIN: state_next = FILL_RSP;
         FILL_RSP: begin
            fill_valid_o = 1'b1;
            state_next   = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Read data trails its strobe by one cycle, so RD cycle k lands word k-1.
   always_ff @(posedge clk_i) begin
      if (accept_evict) begin
         for (int i = 0; i < WORDS; i++) words[i] <= evict_data_i[WORD_BITS*i +: WORD_BITS];
      end
      if (state == RD && cnt != '0) words[prev_cnt] <= mem_rdata_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         line_addr   <= '0;
         fill_data_o <= '0;
         fill_addr_o <= '0;
      end else begin
         if (accept_evict) line_addr <= evict_addr_i[ADDR_BITS-1:OFFS];
         else if (accept_req) line_addr <= req_addr_i[ADDR_BITS-1:OFFS];
         if (state == RD_DRAIN) begin
            for (int i = 0; i < WORDS - 1; i++) fill_data_o[WORD_BITS*i +: WORD_BITS] <= words[i];
            fill_data_o[WORD_BITS*(WORDS-1) +: WORD_BITS] <= mem_rdata_i;
            fill_addr_o <= {line_addr, {OFFS{1'b0}}};
         end
      end
   end

endmodule

// File: tb/tb_cache_dma_responder.sv
// tb/tb_cache_dma_responder.sv - self-checking bench for cache_dma_responder
// Transaction-timeline model plus directed and random line traffic.
module tb_cache_dma_responder;

   logic         clk = 1'b0;
   logic         rst_i = 1'b1;
   logic         req_i = 1'b0;
   logic [31:0]  req_addr_i = '0;
   logic [511:0] fill_data_o;
   logic [31:0]  fill_addr_o;
   logic         fill_valid_o;
   logic         evict_i = 1'b0;
   logic [31:0]  evict_addr_i = '0;
   logic [511:0] evict_data_i = '0;
   logic         evict_ack_o;
   logic [31:0]  mem_addr_o;
   logic         mem_rd_o;
   logic         mem_wr_o;
   logic [31:0]  mem_wdata_o;
   logic [31:0]  mem_rdata_i = '0;
   logic         busy_o;

   cache_dma_responder dut (
      .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .req_addr_i(req_addr_i),
      .fill_data_o(fill_data_o), .fill_addr_o(fill_addr_o), .fill_valid_o(fill_valid_o),
      .evict_i(evict_i), .evict_addr_i(evict_addr_i), .evict_data_i(evict_data_i),
      .evict_ack_o(evict_ack_o), .mem_addr_o(mem_addr_o), .mem_rd_o(mem_rd_o),
      .mem_wr_o(mem_wr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Backing memory seen by the DUT (64 KiB window) and the model's byte image.
   bit [31:0] bmem [16384];
   bit [7:0]  ref_mem [65536];
   int        wr_count = 0;

   always @(posedge clk) begin
      if (mem_wr_o) begin
         bmem[mem_addr_o[15:2]] <= mem_wdata_o;
         wr_count <= wr_count + 1;
      end
      mem_rdata_i <= mem_rd_o ? bmem[mem_addr_o[15:2]] : 32'hDEADBEEF;
   end

   // Model: each accepted transaction owns a fixed timeline of cycles after acceptance.
   int           cyc = 0, t0 = 0, d = 0, ra = 0;
   bit           started = 0, act = 0, ev = 0;
   logic [31:0]  mline = '0;
   logic [511:0] mdata = '0, exp_fd = '0;
   logic [31:0]  exp_fa = '0;
   logic         e_busy, e_rd, e_wr, e_ack, e_fv;
   logic [31:0]  e_addr, e_wd;

   always @(negedge clk) begin
      cyc++;
      d = cyc - t0;
      e_busy = 0; e_rd = 0; e_wr = 0; e_ack = 0; e_fv = 0; e_addr = '0; e_wd = '0;
      if (act) begin
         e_busy = 1;
         if (d <= 16) begin
            e_addr = mline + 32'(4 * (d - 1));
            if (ev) begin
               e_wr = 1;
               e_wd = mdata[32*(d-1) +: 32];
            end else begin
               e_rd = 1;
            end
         end else if (ev) begin
            e_ack = 1;
         end else if (d == 18) begin
            e_fv = 1;
            exp_fd = mdata;
            exp_fa = mline;
         end
      end
      if (started) begin
         chk("busy", 512'(busy_o), 512'(e_busy));
         chk("mem_rd", 512'(mem_rd_o), 512'(e_rd));
         chk("mem_wr", 512'(mem_wr_o), 512'(e_wr));
         chk("evict_ack", 512'(evict_ack_o), 512'(e_ack));
         chk("fill_valid", 512'(fill_valid_o), 512'(e_fv));
         chk("fill_data", fill_data_o, exp_fd);
         chk("fill_addr", 512'(fill_addr_o), 512'(exp_fa));
         chk("strobe_overlap", 512'(mem_rd_o & mem_wr_o), 512'(0));
         if (e_rd || e_wr) chk("mem_addr", 512'(mem_addr_o), 512'(e_addr));
         if (e_wr) chk("mem_wdata", 512'(mem_wdata_o), 512'(e_wd));
      end
      if (e_wr) begin
         for (int b = 0; b < 4; b++) ref_mem[int'(e_addr[15:0]) + b] = e_wd[8*b +: 8];
      end
      if (act && ((ev && d == 17) || (!ev && d == 18))) act = 0;
      if (rst_i) begin
         started = 1;
         act = 0;
         exp_fd = '0;
         exp_fa = '0;
      end else if (started && !e_busy && evict_i) begin
         act = 1; ev = 1; t0 = cyc;
         mline = {evict_addr_i[31:6], 6'b0};
         mdata = evict_data_i;
      end else if (started && !e_busy && req_i) begin
         act = 1; ev = 0; t0 = cyc;
         mline = {req_addr_i[31:6], 6'b0};
         for (int k = 0; k < 16; k++) begin
            for (int b = 0; b < 4; b++) begin
               ra = int'(mline[15:0]) + 4 * k + b;
               mdata[32*k + 8*b +: 8] = ref_mem[ra];
            end
         end
      end
   end

   // Driver: holds requests until their completion pulse, scrambling fields once accepted.
   int lat_ack, lat_fill, idle_cnt, fills;

   task automatic run_txn(input bit de, input bit dr, input logic [31:0] ea,
                          input logic [511:0] ed, input logic [31:0] rqa, input int want);
      int n = 0;
      bit seen_busy = 0;
      bit ack, fv, b;
      @(posedge clk); #1;
      evict_i = de; evict_addr_i = ea; evict_data_i = ed;
      req_i = dr; req_addr_i = rqa;
      lat_ack = -1; lat_fill = -1; idle_cnt = 0; fills = 0;
      while ((evict_i || req_i) && n < 200) begin
         @(negedge clk);
         n++;
         ack = evict_ack_o; fv = fill_valid_o; b = busy_o;
         if (ack) lat_ack = n - 1;
         if (fv) begin
            lat_fill = n - 1;
            fills++;
         end
         if (b) seen_busy = 1;
         else if (seen_busy) idle_cnt++;
         @(posedge clk); #1;
         if (ack) evict_i = 0;
         if (fv && fills >= want) req_i = 0;
         if (b && !ack && evict_i) begin
            evict_addr_i = $urandom;
            for (int k = 0; k < 16; k++) evict_data_i[32*k +: 32] = $urandom;
         end
         if (b && !ack && !fv && !evict_i && req_i) req_addr_i = $urandom;
      end
      if (evict_i || req_i) begin
         total++;
         bad++;
         $display("FAIL txn_timeout: got %0d cycles required completion", n);
         evict_i = 0;
         req_i = 0;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got no finish required finish");
      $fatal(1);
   end

   initial begin
      logic [511:0] ed;
      int wc0, n, fvs;
      bit bv;
      for (int k = 0; k < 16; k++) begin
         bmem[(32'h1000 >> 2) + k] = 32'hA0000000 + 32'(k);
         for (int b = 0; b < 4; b++) ref_mem[32'h1000 + 4*k + b] = 8'((32'hA0000000 + 32'(k)) >> (8*b));
      end
      repeat (3) @(posedge clk);
      #1 rst_i = 0;
      @(negedge clk);
      chk("rst_busy", 512'(busy_o), 512'(0));
      chk("rst_fill_data", fill_data_o, 512'(0));
      chk("rst_mem_addr", 512'(mem_addr_o), 512'(0));

      // Fill from 0x1024: line 0x1000, 18-cycle latency.
      run_txn(0, 1, 32'h0, '0, 32'h1024, 1);
      chk("fill_latency", 512'(lat_fill), 512'(18));
      chk("fill_addr_lit", 512'(fill_addr_o), 512'(32'h1000));
      chk("fill_word0_lit", 512'(fill_data_o[31:0]), 512'(32'hA0000000));
      chk("fill_word15_lit", 512'(fill_data_o[511:480]), 512'(32'hA000000F));

      // Writeback to 0x2000.
      for (int k = 0; k < 16; k++) ed[32*k +: 32] = 32'h5A5A0000 + 32'(k);
      wc0 = wr_count;
      run_txn(1, 0, 32'h2000, ed, 32'h0, 1);
      chk("wb_latency", 512'(lat_ack), 512'(17));
      chk("wb_write_count", 512'(wr_count - wc0), 512'(16));
      chk("wb_word1_lit", 512'(bmem[32'h2004 >> 2]), 512'(32'h5A5A0001));
      chk("wb_word15_lit", 512'(bmem[32'h203C >> 2]), 512'(32'h5A5A000F));

      // Simultaneous evict + fill of the same line: fill sees evicted data.
      for (int k = 0; k < 16; k++) ed[32*k +: 32] = $urandom;
      run_txn(1, 1, 32'h3000, ed, 32'h3000, 1);
      chk("sim_ack_latency", 512'(lat_ack), 512'(17));
      chk("sim_fill_latency", 512'(lat_fill), 512'(36));
      chk("sim_fill_data", fill_data_o, ed);

      // Reset while reading word 7.
      @(posedge clk); #1;
      req_i = 1; req_addr_i = 32'h1000;
      n = 0;
      while (!(mem_rd_o && mem_addr_o == 32'h1018) && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rd_word6_reached", 512'(mem_addr_o), 512'(32'h1018));
      @(posedge clk); #1;
      rst_i = 1; req_i = 0;
      @(posedge clk); #1;
      rst_i = 0;
      @(negedge clk);
      chk("abort_busy", 512'(busy_o), 512'(0));
      chk("abort_fill_valid", 512'(fill_valid_o), 512'(0));
      chk("abort_strobes", 512'({mem_rd_o, mem_wr_o, evict_ack_o}), 512'(0));
      chk("abort_mem_addr", 512'(mem_addr_o), 512'(0));
      chk("abort_fill_data", fill_data_o, 512'(0));
      chk("abort_fill_addr", 512'(fill_addr_o), 512'(0));
      fvs = 0;
      repeat (20) begin
         @(negedge clk);
         bv = fill_valid_o;
         if (bv) fvs++;
      end
      chk("abort_no_fill", 512'(fvs), 512'(0));
      run_txn(0, 1, 32'h0, '0, 32'h1040, 1);
      chk("post_abort_latency", 512'(lat_fill), 512'(18));

      // Request held one cycle past its fill: second fill, single idle gap.
      run_txn(0, 1, 32'h0, '0, 32'h1000, 2);
      chk("b2b_fills", 512'(fills), 512'(2));
      chk("b2b_idle_gap", 512'(idle_cnt), 512'(1));

      // Mixed random traffic over a 32-line window.
      for (int i = 0; i < 2000; i++) begin
         int r;
         logic [31:0] ea, rqa;
         r = $urandom_range(0, 9);
         ea  = 32'h4000 + 32'($urandom_range(0, 31)) * 64 + 32'($urandom_range(0, 63));
         rqa = (r == 9 && $urandom_range(0, 1) == 1) ? ea
               : 32'h4000 + 32'($urandom_range(0, 31)) * 64 + 32'($urandom_range(0, 63));
         for (int k = 0; k < 16; k++) ed[32*k +: 32] = $urandom;
         run_txn(r <= 3 || r == 9, r >= 4, ea, ed, rqa, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cache_dma_responder.md
CACHE_DMA_RESPONDER -- requirements
Module: cache_dma_responder

Interface
REQ-001 SHALL have parameter BLOCK_BITS, default 512, meaning cache line width in bits.
REQ-002 SHALL have parameter WORD_BITS, default 32, meaning memory port data width; WORDS = BLOCK_BITS/WORD_BITS (16).
REQ-003 SHALL have parameter ADDR_BITS, default 32, meaning byte address width.
REQ-004 SHALL have one clock, clk_i, and a synchronous active-high reset, rst_i.
REQ-005 Ports, in order:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous active-high reset.
- req_i  in  1  line fill request from cache, held high until fill_valid_o.
- req_addr_i  in  ADDR_BITS  fill byte address; low log2(BLOCK_BITS/8) bits ignored.
- fill_data_o  out  BLOCK_BITS  returned line; word k at bits [WORD_BITS*k +: WORD_BITS].
- fill_addr_o  out  ADDR_BITS  line-aligned address of returned line.
- fill_valid_o  out  1  one-cycle fill completion pulse.
- evict_i  in  1  dirty line writeback request, held high until evict_ack_o.
- evict_addr_i  in  ADDR_BITS  writeback byte address; low bits ignored.
- evict_data_i  in  BLOCK_BITS  writeback line, same word ordering as fill_data_o.
- evict_ack_o  out  1  one-cycle writeback completion pulse.
- mem_addr_o  out  ADDR_BITS  word byte address to backing memory.
- mem_rd_o  out  1  memory read strobe.
- mem_wr_o  out  1  memory write strobe.
- mem_wdata_o  out  WORD_BITS  memory write data.
- mem_rdata_i  in  WORD_BITS  read data, valid exactly one cycle after mem_rd_o.
- busy_o  out  1  high in every state except IDLE.

Function
REQ-006 SHALL implement FSM states IDLE, WB, WB_ACK, RD, RD_DRAIN, FILL_RSP.
REQ-007 IDLE: evict_i high -> latch evict_addr_i (line-aligned) and evict_data_i, go WB; else req_i high -> latch req_addr_i (line-aligned), go RD; else stay.
REQ-008 evict_i and req_i both high in IDLE SHALL select eviction first; req_i served after WB_ACK returns to IDLE.
REQ-009 WB: WORDS cycles, cycle k drives mem_wr_o=1, mem_addr_o={line, k, 2'b00}, mem_wdata_o=latched word k; after k=WORDS-1 go WB_ACK.
REQ-010 WB_ACK: evict_ack_o=1 for exactly one cycle, then IDLE.
REQ-011 RD: WORDS cycles, cycle k drives mem_rd_o=1, mem_addr_o={line, k, 2'b00}; mem_rdata_i captured into line word k-1 for k>=1; after k=WORDS-1 go RD_DRAIN.
REQ-012 RD_DRAIN: capture word WORDS-1, no memory strobe, go FILL_RSP.
REQ-013 FILL_RSP: fill_valid_o=1 one cycle with fill_data_o complete and fill_addr_o=latched line address, then IDLE.
REQ-014 fill_valid_o SHALL rise exactly WORDS+2 (18) cycles after the IDLE cycle accepting req_i; evict_ack_o exactly WORDS+1 (17) cycles after the IDLE cycle accepting evict_i.
REQ-015 mem_rd_o and mem_wr_o SHALL never both be high; both low outside RD/WB.
REQ-016 Word counter SHALL be log2(WORDS) bits, reset to 0 on every state entry; no wrap beyond WORDS-1.
REQ-017 fill_data_o and fill_addr_o SHALL hold last returned values until next FILL_RSP.
REQ-018 Inputs req_addr_i, evict_addr_i, evict_data_i SHALL be ignored outside the IDLE accept cycle.
REQ-019 A request still high in the IDLE cycle after its ack SHALL be treated as a new request.

Reset
REQ-020 rst_i high at a rising edge SHALL force IDLE, counter 0, fill_valid_o=0, evict_ack_o=0, mem_rd_o=0, mem_wr_o=0, busy_o=0, fill_data_o=0, fill_addr_o=0, mem_addr_o=0, mem_wdata_o=0.
REQ-021 Reset mid-WB or mid-RD SHALL abort without ack or fill pulse; memory words already written are not restored.

Verification
REQ-022 Fill: memory word at 0x1000+4k = 0xA0000000+k, req_i=1 addr 0x1024 -> reads 0x1000..0x103C, fill_valid_o 18 cycles later, fill_addr_o=0x1000, word k=0xA0000000+k.
REQ-023 Writeback: evict_i=1 addr 0x2000, data word k=0x5A5A0000+k -> 16 consecutive mem_wr_o to 0x2000..0x203C with matching data, evict_ack_o after 17 cycles.
REQ-024 Simultaneous: evict_i addr 0x3000 and req_i addr 0x3000 same cycle -> writeback completes first, fill returns evicted data.
REQ-025 Reset mid-RD at word 7 -> no fill_valid_o, all outputs 0 next cycle, new req_i served with full 18-cycle latency.
REQ-026 Back-to-back: req_i held one cycle past fill_valid_o -> second full fill issued, busy_o continuously high except one IDLE cycle.
REQ-027 Random: 2000 mixed fills/evictions against a reference byte-array memory -> every fill matches model, no strobe overlap.
